// File: rtl/seg_pkg.sv
// Shared constants and types for the four-digit segment scan controller.
// Holds the one-hot digit selects, the dark anode code and the scan state encoding.
package seg_pkg;

    localparam logic [3:0] DIG_A     = 4'h1;
    localparam logic [3:0] DIG_B     = 4'h2;
    localparam logic [3:0] DIG_C     = 4'h4;
    localparam logic [3:0] DIG_D     = 4'h8;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } seg_state_t;

    // Map a slot index onto its one-hot digit select
    function automatic logic [3:0] sel_of_slot(input logic [1:0] slot);
        logic [3:0] sel;
        case (slot)
            2'd0:    sel = DIG_A;
            2'd1:    sel = DIG_B;
            2'd2:    sel = DIG_C;
            2'd3:    sel = DIG_D;
            default: sel = DIG_A;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Scan-tick generator: divides clk by TICK_DIV and flags the last count of each period.
// clr holds the count at zero so the first tick after a clear is a full period away.
module seg_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] CNT_LAST = 16'(TICK_DIV - 1);

    logic [15:0] r_cnt;

    // Free-running divider counter with clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (clr) begin
            r_cnt <= 16'd0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed four-digit display scanner: rotates a one-hot digit select every slot,
// gates each digit with a blanked, brightness-limited on-window and drives the anodes.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int TICK_DIV    = 1000,
    parameter int SLOT_TICKS  = 16,
    parameter int BLANK_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] brightness,
    input  logic [3:0] digit_en,
    output logic [3:0] select,
    output logic       enable,
    output logic [3:0] anode_n,
    output logic       frame_done
);

    localparam logic [9:0] BLANK_W = 10'(BLANK_TICKS);
    localparam logic [9:0] SLOT_W  = 10'(SLOT_TICKS);
    localparam logic [7:0] T_LAST  = 8'(SLOT_TICKS - 1);

    seg_state_t r_state, w_state_nx;
    logic [7:0] r_t, w_t_nx;
    logic [1:0] r_slot, w_slot_nx;
    logic [3:0] r_bright, w_bright_nx;
    logic [3:0] r_mask, w_mask_nx;
    logic [3:0] r_select, w_select_nx;
    logic       r_enable, w_enable_nx;
    logic       r_frame_done, w_frame_nx;
    logic [3:0] r_anode_n;
    logic       w_tick;
    logic       w_clr;

    // Ten-bit window bound so BLANK_TICKS+15 cannot overflow before the clamp
    function automatic logic lit(input logic [7:0] t, input logic [1:0] slot,
                                 input logic [3:0] br, input logic [3:0] mask);
        logic [9:0] hi;
        hi = BLANK_W + {6'd0, br};
        hi = (hi > SLOT_W) ? SLOT_W : hi;
        return mask[slot] && ({2'd0, t} >= BLANK_W) && ({2'd0, t} < hi);
    endfunction

    assign w_clr = (r_state != ST_SCAN) || !run;

    seg_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // Next-state, slot rotation and registered-output precompute
    always_comb begin
        w_state_nx  = r_state;
        w_t_nx      = r_t;
        w_slot_nx   = r_slot;
        w_bright_nx = r_bright;
        w_mask_nx   = r_mask;
        w_frame_nx  = 1'b0;
        if (!run) begin
            w_state_nx = ST_IDLE;
            w_t_nx     = 8'd0;
            w_slot_nx  = 2'd0;
        end else if (r_state == ST_IDLE) begin
            w_state_nx  = ST_SCAN;
            w_t_nx      = 8'd0;
            w_slot_nx   = 2'd0;
            w_bright_nx = brightness;
            w_mask_nx   = digit_en;
        end else if (w_tick) begin
            if (r_t == T_LAST) begin
                w_t_nx      = 8'd0;
                w_slot_nx   = r_slot + 2'd1;
                w_bright_nx = brightness;
                w_mask_nx   = digit_en;
                w_frame_nx  = (r_slot == 2'd3);
            end else begin
                w_t_nx = r_t + 8'd1;
            end
        end else begin
            w_t_nx = r_t;
        end
        w_select_nx = sel_of_slot(w_slot_nx);
        w_enable_nx = (w_state_nx == ST_SCAN) && lit(w_t_nx, w_slot_nx, w_bright_nx, w_mask_nx);
    end

    // State, counters, latches and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_t          <= 8'd0;
            r_slot       <= 2'd0;
            r_bright     <= 4'd0;
            r_mask       <= 4'd0;
            r_select     <= DIG_A;
            r_enable     <= 1'b0;
            r_frame_done <= 1'b0;
            r_anode_n    <= DIG_BLANK;
        end else begin
            r_state      <= w_state_nx;
            r_t          <= w_t_nx;
            r_slot       <= w_slot_nx;
            r_bright     <= w_bright_nx;
            r_mask       <= w_mask_nx;
            r_select     <= w_select_nx;
            r_enable     <= w_enable_nx;
            r_frame_done <= w_frame_nx;
            r_anode_n    <= ~(r_select & {4{r_enable}});
        end
    end

    assign select     = r_select;
    assign enable     = r_enable;
    assign anode_n    = r_anode_n;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller (TICK_DIV=4, SLOT_TICKS=16, BLANK_TICKS=1):
// table-driven frames, hand-written corner sequences and a cycle-count reference model.
module tb_seg_scan_controller;

    localparam int TD        = 4;
    localparam int ST        = 16;
    localparam int BL        = 1;
    localparam int SLOT_CYC  = TD * ST;
    localparam int FRAME_CYC = 4 * SLOT_CYC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] brightness = 4'd0;
    logic [3:0] digit_en = 4'd0;
    logic [3:0] select;
    logic       enable;
    logic [3:0] anode_n;
    logic       frame_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_scan_controller #(
        .TICK_DIV    (TD),
        .SLOT_TICKS  (ST),
        .BLANK_TICKS (BL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .brightness (brightness),
        .digit_en   (digit_en),
        .select     (select),
        .enable     (enable),
        .anode_n    (anode_n),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs derived from cycles elapsed since SCAN entry
    bit         m_scan;
    int         m_k;
    logic [3:0] m_br, m_mask, m_anode;
    logic       m_frame;
    bit         model_chk = 1'b0;

    function automatic logic [3:0] exp_sel();
        logic [3:0] one;
        one = 4'b0001;
        return m_scan ? (one << ((m_k / SLOT_CYC) % 4)) : 4'h1;
    endfunction

    function automatic logic exp_en();
        int t, s, hi;
        if (!m_scan) return 1'b0;
        t  = (m_k / TD) % ST;
        s  = (m_k / SLOT_CYC) % 4;
        hi = BL + int'(m_br);
        if (hi > ST) hi = ST;
        return m_mask[s] && (t >= BL) && (t < hi);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_scan  <= 1'b0;
            m_k     <= 0;
            m_br    <= 4'd0;
            m_mask  <= 4'd0;
            m_frame <= 1'b0;
            m_anode <= 4'hF;
        end else begin
            m_anode <= ~(exp_sel() & {4{exp_en()}});
            m_frame <= run && m_scan && (((m_k + 1) % FRAME_CYC) == 0);
            if (!run) begin
                m_scan <= 1'b0;
                m_k    <= 0;
            end else if (!m_scan) begin
                m_scan <= 1'b1;
                m_k    <= 0;
                m_br   <= brightness;
                m_mask <= digit_en;
            end else begin
                m_k <= m_k + 1;
                if (((m_k + 1) % SLOT_CYC) == 0) begin
                    m_br   <= brightness;
                    m_mask <= digit_en;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_chk && rst_n) begin
            check("model_select", select, exp_sel());
            check("model_enable", enable, exp_en());
            check("model_anode_n", anode_n, m_anode);
            check("model_frame_done", frame_done, m_frame);
        end
    end

    typedef struct {
        logic [3:0] br;
        logic [3:0] mask;
        int         on_cyc [4];
    } vec_t;

    vec_t vecs [6];

    // Leave SCAN, load new inputs, re-enter; edge E0 is the next posedge
    task automatic restart(input logic [3:0] br, input logic [3:0] mask);
        @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
        brightness = br;
        digit_en   = mask;
        run        = 1'b1;
    endtask

    task automatic run_frame(input vec_t v, input int n);
        int on [4];
        int fd, an_on, sel_bad, low_bad, tot, idx;
        logic [3:0] one, esel;
        on = '{0, 0, 0, 0};
        fd = 0; an_on = 0; sel_bad = 0; low_bad = 0; tot = 0;
        one = 4'b0001;
        restart(v.br, v.mask);
        for (int c = 0; c <= FRAME_CYC; c++) begin
            @(negedge clk);
            esel = one << ((c / SLOT_CYC) % 4);
            if (select !== esel) sel_bad++;
            idx = (c / SLOT_CYC) % 4;
            if (enable === 1'b1) on[idx]++;
            if (enable === 1'b1 && (c % SLOT_CYC) < TD) low_bad++;
            if (frame_done === 1'b1) fd++;
            if (anode_n !== 4'hF) an_on++;
        end
        for (int d = 0; d < 4; d++) begin
            check($sformatf("vec%0d_on_digit%0d", n, d), on[d], v.on_cyc[d]);
            tot += v.on_cyc[d];
        end
        check($sformatf("vec%0d_select_steps", n), sel_bad, 0);
        check($sformatf("vec%0d_blank_low", n), low_bad, 0);
        check($sformatf("vec%0d_frame_pulses", n), fd, 1);
        check($sformatf("vec%0d_anode_on", n), an_on, tot);
    endtask

    initial begin
        int on0, on1, on2;
        vecs[0] = '{br: 4'd15, mask: 4'hF,    on_cyc: '{60, 60, 60, 60}};
        vecs[1] = '{br: 4'd3,  mask: 4'hF,    on_cyc: '{12, 12, 12, 12}};
        vecs[2] = '{br: 4'd3,  mask: 4'b0101, on_cyc: '{12, 0, 12, 0}};
        vecs[3] = '{br: 4'd0,  mask: 4'hF,    on_cyc: '{0, 0, 0, 0}};
        vecs[4] = '{br: 4'd7,  mask: 4'b1010, on_cyc: '{0, 28, 0, 28}};
        vecs[5] = '{br: 4'd1,  mask: 4'b1000, on_cyc: '{0, 0, 0, 4}};

        #12;
        check("rst_select", select, 4'h1);
        check("rst_enable", enable, 1'b0);
        check("rst_anode_n", anode_n, 4'hF);
        check("rst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_chk = 1'b1;

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        // Brightness drop mid-slot only darkens the following slot
        restart(4'd15, 4'hF);
        on0 = 0; on1 = 0; on2 = 0;
        for (int c = 0; c < 3 * SLOT_CYC; c++) begin
            @(negedge clk);
            if (enable === 1'b1) begin
                if (c < SLOT_CYC) on0++;
                else if (c < 2 * SLOT_CYC) on1++;
                else on2++;
            end
            if (c == 20) brightness = 4'd0;
            if (c == 100) brightness = 4'd15;
        end
        check("midslot_cur_slot", on0, 60);
        check("midslot_next_dark", on1, 0);
        check("midslot_restored", on2, 60);

        // run falls exactly on the D->A wrap edge
        restart(4'd15, 4'hF);
        for (int c = 0; c < FRAME_CYC; c++) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check("wrapdrop_frame_done", frame_done, 1'b0);
        check("wrapdrop_select", select, 4'h1);
        check("wrapdrop_enable", enable, 1'b0);
        check("wrapdrop_anode_lag", anode_n, 4'h7);
        @(negedge clk);
        check("wrapdrop_anode_dark", anode_n, 4'hF);

        // Randomised run / brightness / mask activity against the model
        run = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (run && $urandom_range(0, 399) == 0) run = 1'b0;
            else if (!run && $urandom_range(0, 9) == 0) run = 1'b1;
            if ($urandom_range(0, 39) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 59) == 0) digit_en = 4'($urandom);
        end

        // Asynchronous reset in slot B while lit
        restart(4'd15, 4'hF);
        for (int c = 0; c <= 70; c++) @(negedge clk);
        check("async_pre_select", select, 4'h2);
        check("async_pre_enable", enable, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_select", select, 4'h1);
        check("async_enable", enable, 1'b0);
        check("async_anode_n", anode_n, 4'hF);
        check("async_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
